// File: rtl/knap_enum.sv
// Exhaustive selection-vector enumerator for the knapsack feasibility checker.
// It walks sel = 0..2^N-1, buffers each feasible vector in a one-entry register and counts the hits.
module knap_enum #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sel,
  input  logic         chk_valid,
  output logic         sol_valid,
  input  logic         sol_ready,
  output logic [N-1:0] sol_data,
  output logic [N:0]   sol_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam logic [N-1:0] CNT_MAX = '1;

  state_t       state;
  state_t       state_next;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_next;
  logic [N:0]   count_next;
  logic         load;
  logic         pop;
  logic         can_load;
  logic         stall;

  // A feasible candidate that cannot be buffered freezes the scan until the register drains.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    count_next = sol_count;
    load       = 1'b0;
    pop        = sol_valid && sol_ready;
    can_load   = !sol_valid || sol_ready;
    stall      = chk_valid && !can_load;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_next   = '0;
          count_next = '0;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (!stall) begin
          if (chk_valid) begin
            load       = 1'b1;
            count_next = sol_count + (N+1)'(1);
          end
          if (cnt == CNT_MAX) begin
            state_next = DRAIN;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (can_load) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign sel  = (state == SCAN) ? cnt : '0;
  assign busy = (state == SCAN) || (state == DRAIN);
  assign done = (state == DONE);

  // A simultaneous pop and load keeps sol_valid high with the new vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sol_count <= '0;
      sol_valid <= 1'b0;
      sol_data  <= '0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      sol_count <= count_next;
      if (load) begin
        sol_valid <= 1'b1;
        sol_data  <= cnt;
      end else if (pop) begin
        sol_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/knap_enum.md
# knap_enum

Exhaustive candidate enumerator for the knapsack feasibility checker. On `start` it walks every selection vector from 0 to 2^N-1 on `sel`, which drives the combinational checker's item inputs. It samples the checker's `valid` result in the same cycle and streams each feasible vector downstream over a valid/ready handshake, with a one-entry holding register. It also reports the total count of feasible vectors and a one-cycle `done` pulse when the scan is complete.

## Interface
- N, 5, number of items; width of `sel` and `sol_data`.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a scan; sampled only in IDLE.
- busy  out  1  high in SCAN and DRAIN.
- done  out  1  one-cycle pulse in state DONE.
- sel  out  N  candidate vector to the checker. sel[N-1] maps to the checker's first item input (A), sel[0] to the last (E).
- chk_valid  in  1  checker result for the current `sel`; combinational, same cycle.
- sol_valid  out  1  holding register is full.
- sol_ready  in  1  downstream accepts when sol_valid && sol_ready.
- sol_data  out  N  feasible vector in the holding register.
- sol_count  out  N+1  number of feasible vectors found in the current or last scan.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- Internal counter `cnt` is N bits; `sel = cnt` in SCAN and `sel = 0` in every other state.
- IDLE:
  - When `start` is high: `cnt` <= 0, `sol_count` <= 0, go to SCAN.
  - Otherwise stay in IDLE.
  - `sol_count` and `sol_data` keep their last values.
- Holding register:
  - `pop` = sol_valid && sol_ready.
  - `can_load` = !sol_valid || sol_ready.
  - If load occurs, `sol_valid` <= 1 and `sol_data` <= cnt.
  - Else if `pop` occurs, `sol_valid` <= 0.
- SCAN:
  - `stall` = chk_valid && !can_load.
  - When not stalled:
    - If chk_valid, load the holding register and increment `sol_count`.
    - If `cnt` == 2^N-1, go to DRAIN; otherwise `cnt` <= cnt+1.
  - When stalled: `cnt`, `sel` and `sol_count` hold, and chk_valid is re-sampled next cycle.
  - Infeasible vectors never stall.
- DRAIN:
  - Holding register pops normally.
  - When `can_load` is true (empty, or popping this cycle), go to DONE.
- DONE:
  - `done` = 1 for exactly one cycle, `busy` = 0, then go to IDLE.
  - `start` is ignored in DONE.
- `start` is ignored in SCAN and DRAIN.
- `sol_count` never wraps: the maximum is 2^N, which fits in N+1 bits.
- Vectors are emitted strictly in ascending order, with no loss and no duplication.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0, `sel` = 0.
  - `busy` = 0, `done` = 0.
  - `sol_valid` = 0, `sol_data` = 0, `sol_count` = 0.
- `rst` takes effect at the next edge from any state. A scan interrupted mid-way is abandoned, a pending solution is discarded, and no `done` pulse is produced.
- With sol_ready held at 1, for `start` sampled at edge 0:
  - SCAN occupies cycles 1 .. 2^N.
  - DRAIN occupies cycle 2^N+1.
  - `done` is high in cycle 2^N+2.
  - `busy` is high in cycles 1 .. 2^N+1.
- Each backpressure stall adds exactly one cycle per stalled cycle.
- `sol_data` and `sol_valid` are registered: a feasible `cnt` seen in cycle k appears on `sol_data` in cycle k+1.
- `sol_data` is stable while sol_valid && !sol_ready.
- `sol_count` is final by the cycle in which `done` is high.
- Simultaneous pop and load in the same cycle: the register is reloaded and `sol_valid` stays 1.

## Test plan
- Real checker instance, sol_ready=1, `start` pulse:
  - Exactly one solution, sol_data=5'h0F (items B,C,D,E).
  - sol_count=1.
  - `done` in cycle 34.
- Bench model chk_valid=sel[0], sol_ready=1:
  - 16 solutions 1,3,...,31 in order.
  - sol_count=16.
  - `done` in cycle 34.
- chk_valid=1 always, sol_ready toggling 1,0,1,0,...:
  - All of 0..31 are emitted in order with no gaps or duplicates.
  - sol_count=32 (6'd32, no wrap).
  - `done` is delayed by the exact number of stall cycles.
- chk_valid=1, sol_ready=0 for 10 cycles starting at cnt=4:
  - `sel` holds 5.
  - sol_data holds 4 and is stable.
  - After release, 5 is emitted next.
- `rst` asserted mid-scan at cnt=12:
  - Next cycle shows IDLE, sel=0, sol_valid=0, sol_count=0, no `done`.
  - A following `start` rescans from 0.
- Boundary and ignore checks:
  - `start` during SCAN and in the DONE cycle is ignored, so only one `done` is produced.
  - chk_valid=0 throughout gives sol_count=0 and `done` in cycle 34.
